// File: rtl/aes_key_sched_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_pkg : shared constants, types and S-box for AES-128 key expansion  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package aes_pkg;

  localparam int AES_ROUNDS   = 10;
  localparam int AES_RK_SLOTS = 11;

  typedef logic [127:0] rk_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } state_t;

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] C_SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return C_SBOX_TBL[(255 - int'(b)) * 8 +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    case (r)
      4'd0: v = 8'h01;
      4'd1: v = 8'h02;
      4'd2: v = 8'h04;
      4'd3: v = 8'h08;
      4'd4: v = 8'h10;
      4'd5: v = 8'h20;
      4'd6: v = 8'h40;
      4'd7: v = 8'h80;
      4'd8: v = 8'h1b;
      4'd9: v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_sched_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_sched_ctrl_if : key-load handshake and round-key read port    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
interface aes_key_sched_ctrl_if;
  import aes_pkg::*;

  logic                    key_in_valid;
  logic                    key_in_ready;
  rk_t                     key_in;
  logic                    busy;
  logic                    done;
  logic [AES_RK_SLOTS-1:0] rk_valid_mask;
  logic                    rk_rd_en;
  logic [3:0]              rk_rd_idx;
  rk_t                     rk_rd_data;
  logic                    rk_rd_valid;

  modport master (
    output key_in_valid, key_in, rk_rd_en, rk_rd_idx,
    input  key_in_ready, busy, done, rk_valid_mask, rk_rd_data, rk_rd_valid
  );

  modport slave (
    input  key_in_valid, key_in, rk_rd_en, rk_rd_idx,
    output key_in_ready, busy, done, rk_valid_mask, rk_rd_data, rk_rd_valid
  );

endinterface
`default_nettype wire

// File: rtl/aes_key_sched_ctrl_gen_key.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | gen_key : one AES-128 key-expansion round (combinational)             |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module gen_key
  import aes_pkg::*;
(
  input  rk_t        i_key,
  input  logic [3:0] i_round,
  output rk_t        o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3, w_rot, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;
  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_temp = {sbox(w_rot[31:24]) ^ rcon(i_round),
                   sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};

  assign w_n0  = w_w0 ^ w_temp;
  assign w_n1  = w_w1 ^ w_n0;
  assign w_n2  = w_w2 ^ w_n1;
  assign w_n3  = w_w3 ^ w_n2;
  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | aes_key_sched_ctrl : AES-128 key expansion sequencer with 11-slot     |
// | round-key file. Optional macro: AES_KEY_ZEROIZE_EN (zeroize input).   |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_sched_ctrl_if.slave kif
);

  localparam logic [3:0] C_LAST_ROUND = 4'(AES_ROUNDS - 1);
  localparam logic [3:0] C_NUM_SLOTS  = 4'(AES_RK_SLOTS);

  state_t                  r_state, w_state_next;
  logic [3:0]              r_round;
  rk_t                     r_work;
  rk_t                     r_slots [AES_RK_SLOTS];
  logic [AES_RK_SLOTS-1:0] r_mask;
  rk_t                     r_rd_data;
  logic                    r_rd_valid;

  logic       w_zero, w_ready, w_accept, w_expand, w_last, w_done;
  logic [3:0] w_wr_idx;
  rk_t        w_gen_key;

`ifdef AES_KEY_ZEROIZE_EN
  assign w_zero = zeroize;
`else
  assign w_zero = 1'b0;
`endif

  assign w_ready  = (r_state != ST_EXPAND);
  assign w_accept = kif.key_in_valid & w_ready;
  assign w_expand = (r_state == ST_EXPAND);
  assign w_last   = w_expand && (r_round == C_LAST_ROUND);
  assign w_wr_idx = r_round + 4'd1;

  gen_key u_gen_key (
    .i_key   (r_work),
    .i_round (r_round),
    .o_key   (w_gen_key)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    if (w_zero) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_READY: if (kif.key_in_valid) w_state_next = ST_EXPAND;
        ST_EXPAND: begin
          if (r_round == C_LAST_ROUND) begin
            w_state_next = ST_READY;
            w_done       = ~rst;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Zeroize shares the reset path so that no key material survives it.
  always_ff @(posedge clk) begin
    if (rst || w_zero) begin
      for (int i = 0; i < AES_RK_SLOTS; i++) r_slots[i] <= '0;
      r_work     <= '0;
      r_mask     <= '0;
      r_round    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_slots[0] <= kif.key_in;
        r_work     <= kif.key_in;
        r_mask     <= {{(AES_RK_SLOTS-1){1'b0}}, 1'b1};
        r_round    <= '0;
      end else if (w_expand) begin
        r_slots[w_wr_idx] <= w_gen_key;
        r_work            <= w_gen_key;
        r_mask[w_wr_idx]  <= 1'b1;
        r_round           <= w_last ? 4'd0 : r_round + 4'd1;
      end

      // Mask and slots are sampled before this edge's update.
      if (kif.rk_rd_en) begin
        if (kif.rk_rd_idx < C_NUM_SLOTS) begin
          r_rd_data  <= r_slots[kif.rk_rd_idx];
          r_rd_valid <= r_mask[kif.rk_rd_idx];
        end else begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end
      end else begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign kif.key_in_ready  = w_ready;
  assign kif.busy          = w_expand;
  assign kif.done          = w_done;
  assign kif.rk_valid_mask = r_mask;
  assign kif.rk_rd_data    = r_rd_data;
  assign kif.rk_rd_valid   = r_rd_valid;

endmodule
`default_nettype wire
